// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch_unit (master) and imem (slave).
interface fetch_unit_if #(
    parameter int unsigned pc_width    = 10,
    parameter int unsigned instr_width = 16
);
    logic                   imem_req;
    logic [pc_width-1:0]    imem_addr;
    logic                   imem_ack;
    logic [instr_width-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// IF stage: one-outstanding imem fetch, stall hold buffer, branch redirect/flush.
// Optional halt-on-all-ones instruction is enabled by defining FETCH_HALT_EN.
module fetch_unit #(
    parameter int unsigned            pc_width    = 10,
    parameter int unsigned            instr_width = 16,
    parameter logic [pc_width-1:0]    RESET_PC    = '0,
    parameter logic [instr_width-1:0] NOP_INSTR   = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   br_taken,
    input  logic [pc_width-1:0]    br_target,
    fetch_unit_if.master           imem,
    output logic [pc_width-1:0]    pc_curr_if,
    output logic [instr_width-1:0] instr_if,
    output logic                   valid_if,
    output logic                   halted
);

`ifdef FETCH_HALT_EN
    typedef enum logic [2:0] {IDLE, FETCH, HOLD, FLUSH, HALTED} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, HOLD, FLUSH} state_t;
`endif

    state_t                 state, state_nxt;
    logic [pc_width-1:0]    pc, pc_nxt;
    logic                   req_nxt;
    logic [pc_width-1:0]    addr_nxt;
    logic [pc_width-1:0]    pc_curr_nxt;
    logic [instr_width-1:0] instr_nxt;
    logic                   valid_nxt;
    logic                   halted_nxt;
    logic [pc_width-1:0]    buf_pc, buf_pc_nxt;
    logic [instr_width-1:0] buf_instr, buf_instr_nxt;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            imem.imem_req  <= 1'b0;
            imem.imem_addr <= RESET_PC;
            pc_curr_if     <= RESET_PC;
            instr_if       <= NOP_INSTR;
            valid_if       <= 1'b0;
            halted         <= 1'b0;
            buf_pc         <= '0;
            buf_instr      <= '0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            imem.imem_req  <= req_nxt;
            imem.imem_addr <= addr_nxt;
            pc_curr_if     <= pc_curr_nxt;
            instr_if       <= instr_nxt;
            valid_if       <= valid_nxt;
            halted         <= halted_nxt;
            buf_pc         <= buf_pc_nxt;
            buf_instr      <= buf_instr_nxt;
        end
    end

    // Next-state and next-output logic; outputs hold unless explicitly updated
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        req_nxt       = imem.imem_req;
        addr_nxt      = imem.imem_addr;
        pc_curr_nxt   = pc_curr_if;
        instr_nxt     = instr_if;
        valid_nxt     = valid_if;
        halted_nxt    = halted;
        buf_pc_nxt    = buf_pc;
        buf_instr_nxt = buf_instr;

        if (br_taken) begin
            // Redirect wins over stall and ack; buffered data is dropped by leaving HOLD
            pc_nxt     = br_target;
            valid_nxt  = 1'b0;
            instr_nxt  = NOP_INSTR;
            halted_nxt = 1'b0;
            if ((state == FETCH || state == FLUSH) && !imem.imem_ack) begin
                state_nxt = FLUSH;
            end else begin
                state_nxt = FETCH;
                req_nxt   = 1'b1;
                addr_nxt  = br_target;
            end
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = FETCH;
                    req_nxt   = 1'b1;
                    addr_nxt  = pc;
                end
                FETCH: begin
                    if (imem.imem_ack) begin
                        pc_nxt = pc + pc_width'(1);
                        if (stall) begin
                            buf_pc_nxt    = pc;
                            buf_instr_nxt = imem.imem_rdata;
                            req_nxt       = 1'b0;
                            state_nxt     = HOLD;
                        end else begin
                            pc_curr_nxt = pc;
                            instr_nxt   = imem.imem_rdata;
                            valid_nxt   = 1'b1;
                            addr_nxt    = pc + pc_width'(1);
`ifdef FETCH_HALT_EN
                            if (imem.imem_rdata == '1) begin
                                state_nxt  = HALTED;
                                req_nxt    = 1'b0;
                                halted_nxt = 1'b1;
                            end
`endif
                        end
                    end else if (!stall) begin
                        valid_nxt = 1'b0;
                        instr_nxt = NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc_curr_nxt = buf_pc;
                        instr_nxt   = buf_instr;
                        valid_nxt   = 1'b1;
                        state_nxt   = FETCH;
                        req_nxt     = 1'b1;
                        addr_nxt    = pc;
`ifdef FETCH_HALT_EN
                        if (buf_instr == '1) begin
                            state_nxt  = HALTED;
                            req_nxt    = 1'b0;
                            halted_nxt = 1'b1;
                        end
`endif
                    end
                end
                FLUSH: begin
                    // Returned data belongs to the abandoned path and is dropped
                    if (imem.imem_ack) begin
                        state_nxt = FETCH;
                        req_nxt   = 1'b1;
                        addr_nxt  = pc;
                    end
                end
`ifdef FETCH_HALT_EN
                HALTED: begin
                    if (!stall) begin
                        valid_nxt = 1'b0;
                        instr_nxt = NOP_INSTR;
                    end
                end
`endif
                default: begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized traffic
// checked against a presented-stream / request-stream reference model.
module tb_fetch_unit;
    localparam int unsigned   PW     = 10;
    localparam int unsigned   IW     = 16;
    localparam logic [PW-1:0] RST_PC = '0;
    localparam logic [IW-1:0] NOP    = '0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          br_taken;
    logic [PW-1:0] br_target;
    logic [PW-1:0] pc_curr_if;
    logic [IW-1:0] instr_if;
    logic          valid_if;
    logic          halted;

    fetch_unit_if #(.pc_width(PW), .instr_width(IW)) imem ();

    fetch_unit #(.pc_width(PW), .instr_width(IW), .RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .imem      (imem),
        .pc_curr_if(pc_curr_if),
        .instr_if  (instr_if),
        .valid_if  (valid_if),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    int unsigned   errors = 0;
    int unsigned   checks = 0;
    bit            halt_mode = 1'b0;

    // Reference model state
    logic [PW-1:0] exp_pc, m_pc, m_fetch, m_addr, t_p;
    logic [IW-1:0] m_instr;
    logic          m_valid, m_flush, p_req, a_p, s_p, b_p;
    int unsigned   wcnt, nvalid;

    function automatic logic [IW-1:0] mem_data(input logic [PW-1:0] a);
        if (halt_mode && a == PW'(4)) return 16'hFFFF;
        return IW'(16'h1234) + IW'(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_drive(input bit en);
        imem.imem_ack   = en && imem.imem_req;
        imem.imem_rdata = mem_data(imem.imem_addr);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   32'(imem.imem_req),  32'(0));
        chk({tag, "_addr"},  32'(imem.imem_addr), 32'(RST_PC));
        chk({tag, "_pc"},    32'(pc_curr_if),     32'(RST_PC));
        chk({tag, "_instr"}, 32'(instr_if),       32'(NOP));
        chk({tag, "_valid"}, 32'(valid_if),       32'(0));
        chk({tag, "_halt"},  32'(halted),         32'(0));
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
        imem.imem_ack = 1'b0; imem.imem_rdata = '0;
        tick();
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        chk("idle_req", 32'(imem.imem_req), 32'(0));

        // Ack every cycle: one IDLE cycle, then pc_curr_if 0,1,2,...
        tick();
        chk("first_req",  32'(imem.imem_req),  32'(1));
        chk("first_addr", 32'(imem.imem_addr), 32'(0));
        chk("first_vld",  32'(valid_if),       32'(0));
        mem_drive(1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("seq_pc",    32'(pc_curr_if),     32'(i));
            chk("seq_vld",   32'(valid_if),       32'(1));
            chk("seq_instr", 32'(instr_if),       32'(mem_data(PW'(i))));
            chk("seq_addr",  32'(imem.imem_addr), 32'(i + 1));
            mem_drive(1'b1);
        end

        // Stall for 3 cycles while addr 5 is acknowledged
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_req",   32'(imem.imem_req), 32'(0));
            chk("stall_pc",    32'(pc_curr_if),    32'(4));
            chk("stall_instr", 32'(instr_if),      32'(mem_data(PW'(4))));
            chk("stall_vld",   32'(valid_if),      32'(1));
            mem_drive(1'b1);
        end
        stall = 1'b0;
        tick();
        chk("rel_pc",    32'(pc_curr_if),     32'(5));
        chk("rel_instr", 32'(instr_if),       32'(mem_data(PW'(5))));
        chk("rel_vld",   32'(valid_if),       32'(1));
        chk("rel_addr",  32'(imem.imem_addr), 32'(6));
        mem_drive(1'b1);

        // Redirect while addr 7 is pending, ack two cycles later
        tick();
        chk("pre_br_addr", 32'(imem.imem_addr), 32'(7));
        imem.imem_ack = 1'b0; br_taken = 1'b1; br_target = 10'h3F0;
        tick();
        br_taken = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("flush_vld",  32'(valid_if),       32'(0));
            chk("flush_addr", 32'(imem.imem_addr), 32'(7));
            chk("flush_req",  32'(imem.imem_req),  32'(1));
            mem_drive(k == 1);
            if (k == 0) tick();
        end
        tick();
        chk("tgt_addr", 32'(imem.imem_addr), 32'(10'h3F0));
        chk("tgt_vld",  32'(valid_if),       32'(0));
        mem_drive(1'b1);
        tick();
        chk("tgt_pc",    32'(pc_curr_if), 32'(10'h3F0));
        chk("tgt_instr", 32'(instr_if),   32'(mem_data(10'h3F0)));

        // Redirect coincident with ack: straight to FETCH at the target
        mem_drive(1'b1); br_taken = 1'b1; br_target = 10'h3FE;
        tick();
        br_taken = 1'b0;
        chk("brack_vld",   32'(valid_if),       32'(0));
        chk("brack_instr", 32'(instr_if),       32'(NOP));
        chk("brack_addr",  32'(imem.imem_addr), 32'(10'h3FE));
        mem_drive(1'b1);
        tick();
        chk("brack_pc", 32'(pc_curr_if), 32'(10'h3FE));
        mem_drive(1'b1);

        // PC wrap
        tick();
        chk("wrap_pc",   32'(pc_curr_if),     32'(10'h3FF));
        chk("wrap_addr", 32'(imem.imem_addr), 32'(0));
        mem_drive(1'b0);
        tick();
        chk("bubble_vld",   32'(valid_if),   32'(0));
        chk("bubble_instr", 32'(instr_if),   32'(NOP));
        chk("bubble_pc",    32'(pc_curr_if), 32'(10'h3FF));

        // All-ones instruction at addr 4
        halt_mode = 1'b1;
        mem_drive(1'b1); br_taken = 1'b1; br_target = PW'(4);
        tick();
        br_taken = 1'b0;
        chk("h_addr", 32'(imem.imem_addr), 32'(4));
        mem_drive(1'b1);
        tick();
        chk("h_vld",   32'(valid_if),   32'(1));
        chk("h_instr", 32'(instr_if),   32'(16'hFFFF));
        chk("h_pc",    32'(pc_curr_if), 32'(4));
`ifdef FETCH_HALT_EN
        chk("h_req",  32'(imem.imem_req), 32'(0));
        chk("h_halt", 32'(halted),        32'(1));
        for (int k = 0; k < 3; k++) begin
            mem_drive(1'b1);
            tick();
            chk("hd_vld",  32'(valid_if),      32'(0));
            chk("hd_req",  32'(imem.imem_req), 32'(0));
            chk("hd_halt", 32'(halted),        32'(1));
        end
        br_taken = 1'b1; br_target = PW'(8);
        tick();
        br_taken = 1'b0;
        chk("hx_halt", 32'(halted),         32'(0));
        chk("hx_req",  32'(imem.imem_req),  32'(1));
        chk("hx_addr", 32'(imem.imem_addr), 32'(8));
`else
        chk("h_req",  32'(imem.imem_req),  32'(1));
        chk("h_addr", 32'(imem.imem_addr), 32'(5));
        chk("h_halt", 32'(halted),         32'(0));
        mem_drive(1'b0);
        tick();
        chk("hn_vld",  32'(valid_if), 32'(0));
        chk("hn_halt", 32'(halted),   32'(0));
`endif
        halt_mode = 1'b0;

        // Reset mid-request, then an ack during IDLE must be ignored
        #3 rst_n = 1'b0;
        #1 chk_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        imem.imem_ack = 1'b1; imem.imem_rdata = mem_data(PW'(0));
        tick();
        chk("ign_vld",  32'(valid_if),       32'(0));
        chk("ign_req",  32'(imem.imem_req),  32'(1));
        chk("ign_addr", 32'(imem.imem_addr), 32'(0));

        // Randomized traffic against the reference model
        exp_pc = RST_PC; m_pc = RST_PC; m_instr = NOP; m_valid = 1'b0;
        m_fetch = RST_PC; m_addr = RST_PC; m_flush = 1'b0; wcnt = 0; nvalid = 0;
        for (int n = 0; n < 3000; n++) begin
            stall     = ($urandom_range(0, 3) == 0);
            br_taken  = ($urandom_range(0, 11) == 0);
            br_target = PW'($urandom);
            if (imem.imem_req) begin
                if (wcnt == 0) begin
                    imem.imem_ack = 1'b1;
                    wcnt = $urandom_range(0, 2);
                end else begin
                    imem.imem_ack = 1'b0;
                    wcnt--;
                end
            end else begin
                imem.imem_ack = 1'b0;
            end
            imem.imem_rdata = mem_data(imem.imem_addr);
            p_req = imem.imem_req; a_p = imem.imem_ack;
            s_p = stall; b_p = br_taken; t_p = br_target;
            tick();

            // Presented instruction stream
            if (b_p) begin
                chk("r_br_vld",   32'(valid_if),   32'(0));
                chk("r_br_instr", 32'(instr_if),   32'(NOP));
                chk("r_br_pc",    32'(pc_curr_if), 32'(m_pc));
                m_valid = 1'b0; m_instr = NOP; exp_pc = t_p;
            end else if (s_p) begin
                chk("r_hold_pc",    32'(pc_curr_if), 32'(m_pc));
                chk("r_hold_instr", 32'(instr_if),   32'(m_instr));
                chk("r_hold_vld",   32'(valid_if),   32'(m_valid));
            end else if (valid_if) begin
                chk("r_pc",    32'(pc_curr_if), 32'(exp_pc));
                chk("r_instr", 32'(instr_if),   32'(mem_data(exp_pc)));
                m_pc = exp_pc; m_instr = mem_data(exp_pc); m_valid = 1'b1;
                exp_pc = exp_pc + PW'(1);
                nvalid++;
            end else begin
                chk("r_bub_instr", 32'(instr_if),   32'(NOP));
                chk("r_bub_pc",    32'(pc_curr_if), 32'(m_pc));
                m_valid = 1'b0; m_instr = NOP;
            end

            // Request stream: one outstanding, address stable until ack
            if (b_p) begin
                m_fetch = t_p;
                m_flush = p_req && !a_p;
            end else if (p_req && a_p) begin
                if (m_flush) m_flush = 1'b0;
                else         m_fetch = m_fetch + PW'(1);
            end
            if (p_req && !a_p) begin
                chk("r_req_held", 32'(imem.imem_req),  32'(1));
                chk("r_addr_stb", 32'(imem.imem_addr), 32'(m_addr));
            end else if (imem.imem_req) begin
                chk("r_addr_new", 32'(imem.imem_addr), 32'(m_fetch));
                m_addr = m_fetch;
            end
            chk("r_halt", 32'(halted), 32'(0));
        end
        chk("r_progress", 32'(nvalid > 200), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
